// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the dedup FIFO: reset value of the
// last-accepted register, count width and circular pointer increment.
package fifo_pkg;

    localparam logic [7:0] LAST_RST_DEF = 8'hFD;

    // Count must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned depth);
        return (p >= depth - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: one synchronous write port and one
// combinational read port; no control logic lives here.
module fifo_mem #(
    parameter int DWIDTH = 8,
    parameter int FDEPTH = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] r_mem [FDEPTH];

    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/dedup_fifo.sv
// Circular-buffer FIFO with consecutive-duplicate suppression, threshold
// flags, occupancy count and registered event pulses.
module dedup_fifo
    import fifo_pkg::*;
#(
    parameter int                DWIDTH   = 8,
    parameter int                FDEPTH   = 8,
    parameter int                AF_LEVEL = FDEPTH - 1,
    parameter int                AE_LEVEL = 1,
    parameter bit                DEDUP_EN = 1'b1,
    parameter logic [DWIDTH-1:0] LAST_RST = DWIDTH'(LAST_RST_DEF),
    localparam int               CW       = cnt_width(FDEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              write_i,
    input  logic              force_i,
    input  logic              read_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              rvalid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [CW-1:0]     count_o,
    output logic              drop_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              drained_o
);

    localparam int AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;

    logic [AW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;
    logic [DWIDTH-1:0] r_last, r_data;
    logic              r_rvalid, r_drop, r_ovf, r_unf, r_drained;

    logic              w_full, w_empty, w_dup, w_rd_ok, w_wr_ok;
    logic [CW-1:0]     w_cnt_nxt;
    logic [DWIDTH-1:0] w_rdata;

    assign w_full  = (r_count == CW'(FDEPTH));
    assign w_empty = (r_count == '0);
    assign w_rd_ok = read_i & ~w_empty;
    assign w_dup   = DEDUP_EN & (data_i == r_last) & ~force_i;
    // A pop in the same cycle frees the slot being written, so full only blocks a lone write.
    assign w_wr_ok = write_i & ~w_dup & (~w_full | w_rd_ok);
    assign w_cnt_nxt = r_count + CW'(w_wr_ok) - CW'(w_rd_ok);

    fifo_mem #(
        .DWIDTH (DWIDTH),
        .FDEPTH (FDEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr_ok),
        .waddr (r_wptr),
        .wdata (data_i),
        .raddr (r_rptr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_last    <= LAST_RST;
            r_data    <= '0;
            r_rvalid  <= 1'b0;
            r_drop    <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_drained <= 1'b0;
        end else begin
            r_count   <= w_cnt_nxt;
            r_rvalid  <= w_rd_ok;
            r_drop    <= write_i & w_dup;
            r_ovf     <= write_i & ~w_dup & w_full & ~w_rd_ok;
            r_unf     <= read_i & w_empty;
            r_drained <= ~w_empty & (w_cnt_nxt == '0);
            if (w_wr_ok) begin
                r_wptr <= AW'(ptr_inc(32'(r_wptr), FDEPTH));
                r_last <= data_i;
            end
            if (w_rd_ok) begin
                r_rptr <= AW'(ptr_inc(32'(r_rptr), FDEPTH));
                r_data <= w_rdata;
            end
        end
    end

    assign data_o         = r_data;
    assign rvalid_o       = r_rvalid;
    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign almost_full_o  = (32'(r_count) >= AF_LEVEL);
    assign almost_empty_o = (32'(r_count) <= AE_LEVEL);
    assign count_o        = r_count;
    assign drop_o         = r_drop;
    assign overflow_o     = r_ovf;
    assign underflow_o    = r_unf;
    assign drained_o      = r_drained;

endmodule

// File: doc/dedup_fifo.md
# dedup_fifo

Parametrised synchronous FIFO with optional consecutive-duplicate suppression, programmable almost-full/almost-empty thresholds, occupancy count and drain-complete pulse. It is the general-purpose successor of the HW2 five-entry byte queue and sits between a producer that can repeat symbols and a consumer that pops on demand. It uses circular-buffer storage instead of shifting, so `full_o` and `empty_o` carry no lag.

## Interface
- `DWIDTH`, 8: data width in bits.
- `FDEPTH`, 8: number of entries, ≥2, any integer; pointers wrap at `FDEPTH-1`.
- `AF_LEVEL`, `FDEPTH-1`: `almost_full_o` when count ≥ `AF_LEVEL`.
- `AE_LEVEL`, 1: `almost_empty_o` when count ≤ `AE_LEVEL`.
- `DEDUP_EN`, 1: 1 enables duplicate suppression.
- `LAST_RST`, `8'hFD` (zero-extended to `DWIDTH`): reset value of the last-accepted-data register.
- `CW` (localparam): `$clog2(FDEPTH+1)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `data_i` in `DWIDTH`: write data.
- `write_i` in 1: write request.
- `force_i` in 1: accept the write even if it duplicates the last accepted data.
- `read_i` in 1: pop request.
- `data_o` out `DWIDTH`: popped data, registered.
- `rvalid_o` out 1: `data_o` updated this cycle.
- `full_o` out 1: count == `FDEPTH`.
- `empty_o` out 1: count == 0.
- `almost_full_o` out 1: almost-full threshold flag.
- `almost_empty_o` out 1: almost-empty threshold flag.
- `count_o` out `CW`: current occupancy.
- `drop_o` out 1: pulse, write suppressed as a duplicate.
- `overflow_o` out 1: pulse, write rejected because full.
- `underflow_o` out 1: pulse, read while empty.
- `drained_o` out 1: pulse, count reached 0 this edge.

## Operation
- `rd_ok = read_i & (count != 0)`.
- `dup = DEDUP_EN & (data_i == last_q) & ~force_i`.
- `wr_ok = write_i & ~dup & ((count != FDEPTH) | rd_ok)`.
- Accepted write: store at `wptr`, `wptr` advances and wraps, `last_q <= data_i`. `last_q` changes only on an accepted write.
- Accepted read: `data_o <= mem[rptr]`, `rvalid_o <= 1`, `rptr` advances and wraps. Otherwise `data_o` holds its value and `rvalid_o <= 0`.
- Count update: `count += wr_ok - rd_ok`. Read and write in the same cycle leaves count unchanged, including when full.
- Empty FIFO: no bypass. A simultaneous read and write is treated as write only, with `underflow_o` pulsed.
- Duplicate check has priority over full. If both apply, only `drop_o` pulses.
- `overflow_o` pulses when `write_i & ~dup & full & ~rd_ok`.
- `drained_o` pulses when count goes from nonzero to 0.
- `full_o`, `empty_o`, the almost flags and `count_o` are combinational from registered count.
- Reset (async, any time, including mid-operation):
  - pointers, count, `data_o`, `rvalid_o` and all pulse outputs go to 0;
  - `last_q = LAST_RST`, memory contents are don't-care;
  - `empty_o = 1`, `almost_empty_o = 1`, `full_o = 0`.

## Timing
- Write-to-visible: data written at edge N is readable by a `read_i` sampled at edge N+1.
- Read latency is 1: `read_i` sampled at edge N gives `data_o`/`rvalid_o` valid after edge N.
- Status flags reflect count after edge N, with no extra cycle of lag.
- All pulse outputs are registered, 1 cycle wide, and asserted after the edge that samples the causing request.

## Structure
- Shared package `fifo_pkg`:
  - `LAST_RST` default value;
  - `clog2`-based count-width helper;
  - pointer-increment-with-wrap function.
- Sub-module `fifo_mem`: `FDEPTH`×`DWIDTH` register array with one write port (`we`, `waddr`, `wdata`) and one combinational read port. All control stays in `dedup_fifo`.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 with one per cycle -> `count_o` = 3; three reads give `data_o` 0x11, 0x22, 0x33 each with `rvalid_o`; `drained_o` pulses after the third read.
- Write 0xFD right after reset with `force_i`=0 -> `drop_o` = 1 and count 0. Same write with `force_i`=1 -> accepted, count 1.
- Write 0x05, 0x05, 0x06 -> second write dropped; reads return 0x05, 0x06. With `DEDUP_EN`=0 -> all three stored.
- Fill `FDEPTH`=8 with 0x00..0x07, then write 0x08 -> `overflow_o` pulses, `full_o` held. Then read and write 0x08 together -> count stays 8, `data_o` = 0x00, and after wrap 0x08 is returned last.
- Read while empty -> `underflow_o` pulses, `rvalid_o` = 0, `data_o` unchanged. Empty with read and write 0x44 together -> count 1.
- Assert `rst_n` low with 5 entries stored -> all outputs reach their reset values immediately without waiting for `clk`; `last_q` is 0xFD, so an unforced write of 0xFD is then dropped.
